// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize and debounce board buttons/switches into clean counter controls
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_raw,
  input  logic       btn_rst_raw,
  input  logic [3:0] sw_raw,
  output logic       set_pulse,
  output logic       reset_pulse,
  output logic [3:0] init_val,
  output logic [1:0] btn_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} btn_state_t;

  // Two-flop synchronizer, packed as {sw[3:0], rst, set}
  logic [5:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_raw, btn_rst_raw, btn_set_raw};
      sync2 <= sync1;
    end
  end

  btn_state_t       state_q [2];
  btn_state_t       state_d [2];
  logic [CNT_W-1:0] bcnt_q  [2];
  logic [CNT_W-1:0] bcnt_d  [2];
  logic [1:0]       pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        bcnt_q[i]  <= '0;
      end
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        bcnt_q[i]  <= bcnt_d[i];
      end
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      bcnt_d[i]  = bcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2[i]) begin
            state_d[i] = ARMING;
            bcnt_d[i]  = '0;
          end
        end
        ARMING: begin
          if (!sync2[i]) begin
            state_d[i] = IDLE;
          end else if (bcnt_q[i] == CNT_MAX) begin
            state_d[i] = PRESSED;
            pulse_d[i] = 1'b1;
          end else begin
            bcnt_d[i] = bcnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2[i]) begin
            state_d[i] = RELEASING;
            bcnt_d[i]  = '0;
          end
        end
        RELEASING: begin
          // A bounce back high during release is treated as still held.
          if (sync2[i]) begin
            state_d[i] = PRESSED;
          end else if (bcnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
          end else begin
            bcnt_d[i] = bcnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign set_pulse   = pulse_q[0];
  assign reset_pulse = pulse_q[1];
  assign btn_level   = {(state_q[1] == PRESSED) || (state_q[1] == RELEASING),
                        (state_q[0] == PRESSED) || (state_q[0] == RELEASING)};

  // Whole switch vector shares one qualifier so init_val only moves atomically.
  logic [3:0]       cand_q, init_q;
  logic [CNT_W-1:0] scnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      init_q <= '0;
      scnt_q <= '0;
    end else if (sync2[5:2] != cand_q) begin
      cand_q <= sync2[5:2];
      scnt_q <= '0;
    end else if (scnt_q != CNT_MAX) begin
      scnt_q <= scnt_q + 1'b1;
    end else begin
      init_q <= cand_q;
    end
  end

  assign init_val = init_q;

endmodule
